// File: rtl/alarm_ctrl.sv
// Arm/disarm sequencer for the comb1 alarm-trigger logic: exit delay, entry delay,
// timed siren and alarm memory, with every output registered alongside the state.
module alarm_ctrl #(
  parameter int EXIT_CYCLES  = 8,
  parameter int ENTRY_CYCLES = 6,
  parameter int ALARM_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       door,
  input  logic       trip,
  output logic       armed,
  output logic       siren,
  output logic       chime,
  output logic       alarm_mem,
  output logic [2:0] status
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_armed;
  logic             r_siren;
  logic             r_chime;
  logic             r_mem;
  logic             w_mem_nx;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Priority within each state: disarm > trip > door > counter expiry.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_mem_nx   = r_mem;
    case (r_state)
      S_DISARMED: begin
        if (arm && !disarm) begin
          w_state_nx = S_EXIT;
          w_cnt_nx   = EXIT_LD;
        end
      end
      S_EXIT: begin
        if (disarm) begin
          w_state_nx = S_DISARMED;
        end else if (w_cnt_zero) begin
          w_state_nx = S_ARMED;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      S_ARMED: begin
        if (disarm) begin
          w_state_nx = S_DISARMED;
        end else if (trip) begin
          w_state_nx = S_ALARM;
          w_cnt_nx   = ALARM_LD;
          w_mem_nx   = 1'b1;
        end else if (door) begin
          w_state_nx = S_ENTRY;
          w_cnt_nx   = ENTRY_LD;
        end
      end
      S_ENTRY: begin
        if (disarm) begin
          w_state_nx = S_DISARMED;
        end else if (trip || w_cnt_zero) begin
          w_state_nx = S_ALARM;
          w_cnt_nx   = ALARM_LD;
          w_mem_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      S_ALARM: begin
        if (disarm) begin
          w_state_nx = S_DISARMED;
        end else if (w_cnt_zero) begin
          w_state_nx = S_ARMED;
        end else begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nx = S_DISARMED;
      end
    endcase
    if (disarm) begin
      w_mem_nx = 1'b0;
    end
  end

  // Outputs decode the next state so they change on the same edge as r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_DISARMED;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_siren <= 1'b0;
      r_chime <= 1'b0;
      r_mem   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_armed <= (w_state_nx == S_ARMED) || (w_state_nx == S_ENTRY) ||
                 (w_state_nx == S_ALARM);
      r_siren <= (w_state_nx == S_ALARM);
      r_chime <= (w_state_nx == S_ENTRY);
      r_mem   <= w_mem_nx;
    end
  end

  assign armed     = r_armed;
  assign siren     = r_siren;
  assign chime     = r_chime;
  assign alarm_mem = r_mem;
  assign status    = r_state;

endmodule
